arbitrate: RTL
==============

Name: arbitrate

Overview:
- N-input to one-output stream merger with round-robin arbitration.
- Sits directly downstream of the demultiplex fan-out. It collects the N per-destination streams back into a single stream.
- Each output word is tagged with the index of the input it came from, so a later demultiplex can route it back.
- The output is registered: one-entry skid-free buffer, full throughput of one word per cycle.

Parameters:
- W, 8, data width in bits
- N, 4, number of input streams; legal range 2..16; need not be a power of two

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- s_dat  input  N×W  input data, one W-bit word per input i
- s_stb  input  N  input i has a valid word
- s_ack  output  N  input i's word is accepted this cycle
- m_dat  output  W  output data
- m_idx  output  $clog2(N)  index of the input that m_dat came from
- m_stb  output  1  output word valid
- m_ack  input  1  consumer accepts output this cycle

Behaviour:
- Handshake (all ports):
  - A transfer occurs on a rising edge where stb && ack.
  - A producer holds stb and dat stable until that transfer. It must not withdraw stb.
  - ack may depend combinationally on stb.
- Reset, asynchronous on rst low:
  - m_stb=0, m_dat=0, m_idx=0, priority pointer ptr=0.
  - s_ack=0 while rst is low.
  - Release is synchronous to clk. The first transfer is possible on the first edge after release.
- Output register:
  - full = m_stb.
  - The register can load this cycle when !full || m_ack ("open").
- Grant, combinational:
  - If open, scan inputs in order ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - g = first index with s_stb[g]=1.
  - Assert s_ack[g]=1. All other s_ack bits are 0.
  - If open is false or no s_stb is set, s_ack=0.
  - At most one s_ack bit is set in any cycle.
- On a clock edge with a grant:
  - m_dat<=s_dat[g], m_idx<=g, m_stb<=1.
  - ptr<=(g+1) mod N, wrapping from N-1 to 0 (non-power-of-two N must wrap correctly).
- On a clock edge with no grant:
  - If m_ack && full, then m_stb<=0.
  - Otherwise m_stb, m_dat and m_idx hold.
  - ptr holds.
- Latency: a word accepted at edge t is presented on m_stb/m_dat/m_idx after edge t and is consumable at edge t+1.
- Throughput:
  - With m_ack held high and inputs continuously valid: one word per cycle.
  - Simultaneous drain and load in the same cycle is required. There is no bubble.
- Fairness:
  - With all N inputs continuously valid, grants rotate ptr-order 0,1,…,N-1,0,…
  - No input waits more than N-1 grants.
- Backpressure:
  - While full && !m_ack, s_ack=0 everywhere.
  - m_dat and m_idx stay stable.
  - ptr is unchanged.
- Reset mid-operation: the held word is discarded, m_stb drops immediately and ptr returns to 0. Pending input words remain with their producers.
- No combinational path from m_ack to m_dat, m_idx or m_stb.

Test Plan:
1. Reset then idle: rst low 2 cycles, all s_stb=0 → m_stb=0, s_ack=0000, m_idx=0 throughout 10 cycles.
2. Single input: s_stb=0100, s_dat[2]=8'hA5, m_ack=1 → s_ack=0100 on first edge; next cycle m_stb=1, m_dat=A5, m_idx=2; m_stb=0 after the following edge.
3. Round-robin: all four s_stb=1 with s_dat[i]=8'h10+i, m_ack=1, 8 words → m_idx sequence 0,1,2,3,0,1,2,3, data 10,11,12,13,…, one word per cycle with no gaps.
4. Backpressure: m_ack=0 for 5 cycles with s_stb=1111 → exactly one word loaded (idx 0); s_ack=0000 for the remaining 4 cycles; m_dat stable. Raising m_ack → idx 1 is loaded on the same edge that idx 0 drains.
5. Pointer wrap: grant idx 3 first (s_stb=1000), then s_stb=1001 → next grant idx 0, then idx 3. Repeat with N=3 to check wrap from 2 to 0.
6. Random soak: R=1000 random words on random inputs with random m_ack → every accepted word appears exactly once with the correct m_idx, per-input order is preserved, and each input is served within N-1 grants. Assert rst mid-stream once → m_stb=0 immediately and the stream resumes correctly after release.

Source files
------------

// File: rtl/arbitrate.sv
// N-input to one-output round-robin stream merger. Each output word is tagged
// with the index of the input it came from; the output is a single register.
module arbitrate #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*W-1:0]         s_dat,
    input  logic [N-1:0]           s_stb,
    output logic [N-1:0]           s_ack,
    output logic [W-1:0]           m_dat,
    output logic [$clog2(N)-1:0]   m_idx,
    output logic                   m_stb,
    input  logic                   m_ack
);

    localparam int IW = $clog2(N);

    logic [N-1:0][W-1:0] dat_arr;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_valid;
    logic                open;

    // Input slot reached k steps after base, wrapping at N (N need not be 2^k).
    function automatic logic [IW-1:0] rotate(input logic [IW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N) j = j - N;
        return IW'(j);
    endfunction

    assign dat_arr = s_dat;

    // The register accepts a new word whenever it is empty or being drained.
    assign open = !m_stb || m_ack;

    // Scanning from the far end lets the last hit be the first slot after ptr.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path leaves a signal unassigned (no latch).
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (open) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (s_stb[rotate(ptr, k)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = rotate(ptr, k);
                end
            end
        end
    end

    always_comb begin
        s_ack = '0;
        if (gnt_valid && rst) s_ack[gnt_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; all state here is control or a single word, so all of
    // it is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stb <= 1'b0;
            m_dat <= '0;
            m_idx <= '0;
            ptr   <= '0;
        end else if (gnt_valid) begin
            m_stb <= 1'b1;
            m_dat <= dat_arr[gnt_idx];
            m_idx <= gnt_idx;
            ptr   <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end else if (m_ack && m_stb) begin
            m_stb <= 1'b0;
        end
    end

endmodule
